// File: rtl/word_unpacker.sv
// MSB-aligned bit buffer that accepts packed compressed words and presents the
// oldest bits as a window to a variable-length decoder.
module word_unpacker #(
    parameter int TOTAL_WIDTH = 136,
    parameter int IN_WIDTH    = 68,
    parameter int O_WIDTH     = 68,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [IN_WIDTH-1:0]  i_word,
    input  logic                 i_valid,
    input  logic                 i_last,
    output logic                 o_ready,
    output logic [O_WIDTH-1:0]   o_window,
    output logic                 o_valid,
    input  logic                 i_consume,
    input  logic [6:0]           i_shift_len,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_done,
    output logic                 o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] READY_MAX_C = CNT_WIDTH'(TOTAL_WIDTH - IN_WIDTH);
    localparam logic [CNT_WIDTH-1:0] OW_C        = CNT_WIDTH'(O_WIDTH);
    localparam logic [CNT_WIDTH-1:0] IN_C        = CNT_WIDTH'(IN_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO_C  = {CNT_WIDTH{1'b0}};

    state_t                 state_r;
    state_t                 state_next_s;
    logic [TOTAL_WIDTH-1:0] buf_r;
    logic [TOTAL_WIDTH-1:0] buf_next_s;
    logic [TOTAL_WIDTH-1:0] load_word_s;
    logic [CNT_WIDTH-1:0]   occ_r;
    logic [CNT_WIDTH-1:0]   occ_next_s;
    logic [CNT_WIDTH-1:0]   len_s;
    logic [CNT_WIDTH-1:0]   shift_cap_s;
    logic [CNT_WIDTH-1:0]   shift_s;
    logic                   err_r;
    logic                   ready_s;
    logic                   valid_s;
    logic                   load_s;
    logic                   cons_s;
    logic                   over_s;

    assign ready_s = ((state_r == IDLE) || (state_r == RUN)) && (occ_r <= READY_MAX_C);
    assign load_s  = i_valid && ready_s;
    assign cons_s  = i_consume && valid_s;

    // Shift is clamped to the window width and to the bits actually held.
    assign len_s       = CNT_WIDTH'(i_shift_len);
    assign shift_cap_s = (len_s > OW_C) ? OW_C : len_s;
    assign shift_s     = cons_s ? ((shift_cap_s > occ_r) ? occ_r : shift_cap_s) : CNT_ZERO_C;
    assign over_s      = cons_s && ((len_s > OW_C) || (len_s > occ_r));

    // New word lands directly below the bits that survive this cycle's shift.
    assign load_word_s = {i_word, {(TOTAL_WIDTH - IN_WIDTH){1'b0}}};
    assign buf_next_s  = (buf_r << shift_s) |
                         (load_s ? (load_word_s >> (occ_r - shift_s)) : {TOTAL_WIDTH{1'b0}});
    assign occ_next_s  = occ_r - shift_s + (load_s ? IN_C : CNT_ZERO_C);

    // Window validity per state; a draining stream may expose a partial window.
    always_comb begin
        valid_s = 1'b0;
        case (state_r)
            IDLE:    valid_s = (occ_r >= OW_C);
            RUN:     valid_s = (occ_r >= OW_C);
            DRAIN:   valid_s = (occ_r != CNT_ZERO_C);
            DONE:    valid_s = 1'b0;
            default: valid_s = 1'b0;
        endcase
    end

    // Stream sequencing: fill, drain after the last word, single-cycle done.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_next_s = i_last ? DRAIN : RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (load_s && i_last) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (occ_next_s == CNT_ZERO_C) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Buffer, occupancy, state and sticky error registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= IDLE;
            buf_r   <= {TOTAL_WIDTH{1'b0}};
            occ_r   <= CNT_ZERO_C;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            buf_r   <= buf_next_s;
            occ_r   <= occ_next_s;
            err_r   <= err_r | over_s;
        end
    end

    assign o_ready  = ready_s;
    assign o_window = buf_r[TOTAL_WIDTH-1 -: O_WIDTH];
    assign o_valid  = valid_s;
    assign o_count  = occ_r;
    assign o_done   = (state_r == DONE);
    assign o_err    = err_r;

endmodule

// File: tb/tb_word_unpacker.sv
// Directed self-checking bench for word_unpacker with hand-computed expectations.
module tb_word_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic [67:0] word;
    logic        valid;
    logic        last;
    logic        ready;
    logic [67:0] window;
    logic        ovalid;
    logic        consume;
    logic [6:0]  shift_len;
    logic [7:0]  count;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [67:0] w1 = 68'hF_0000_0000_0000_0001;
    logic [67:0] w2 = 68'h1_2345_6789_ABCD_EF01;
    logic [67:0] w3 = 68'hA_5A5A_5A5A_5A5A_5A5A;
    logic [67:0] w4 = 68'h3_C3C3_0F0F_1234_5678;
    logic [67:0] exp_w;

    word_unpacker dut (
        .i_clk(clk), .i_reset(reset), .i_word(word), .i_valid(valid), .i_last(last),
        .o_ready(ready), .o_window(window), .o_valid(ovalid), .i_consume(consume),
        .i_shift_len(shift_len), .o_count(count), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; last = 1'b0; consume = 1'b0; shift_len = 7'd0; word = 68'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step(); step();
        total++; if (count !== 8'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ovalid); end
        total++; if (window !== 68'd0) begin bad++; $display("FAIL rst_window got=%h exp=0", window); end
        total++; if (err !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_err_done got=%b%b exp=00", err, done); end
        reset = 1'b0;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ready); end
        // consume with nothing buffered must be ignored
        consume = 1'b1; shift_len = 7'd5;
        step();
        total++; if (count !== 8'd0 || err !== 1'b0) begin bad++; $display("FAIL ignored_consume got=%0d/%b exp=0/0", count, err); end
        idle_inputs();
    endtask

    task automatic test_double_load();
        do_reset();
        word = w1; valid = 1'b1;
        step();
        total++; if (count !== 8'd68) begin bad++; $display("FAIL load_count got=%0d exp=68", count); end
        total++; if (ovalid !== 1'b1 || ready !== 1'b1) begin bad++; $display("FAIL load_flags got=%b%b exp=11", ovalid, ready); end
        total++; if (window !== w1) begin bad++; $display("FAIL load_window got=%h exp=%h", window, w1); end
        word = w2;
        step();
        valid = 1'b0;
        total++; if (count !== 8'd136 || ready !== 1'b0) begin bad++; $display("FAIL full got=%0d/%b exp=136/0", count, ready); end
        total++; if (window !== w1) begin bad++; $display("FAIL full_window got=%h exp=%h", window, w1); end
        consume = 1'b1; shift_len = 7'd4;
        step();
        exp_w = 68'h0_0000_0000_0000_0011;
        total++; if (count !== 8'd132 || ready !== 1'b0) begin bad++; $display("FAIL c4 got=%0d/%b exp=132/0", count, ready); end
        total++; if (window !== exp_w) begin bad++; $display("FAIL c4_window got=%h exp=%h", window, exp_w); end
        shift_len = 7'd64;
        step();
        total++; if (count !== 8'd68 || ready !== 1'b1) begin bad++; $display("FAIL c64 got=%0d/%b exp=68/1", count, ready); end
        total++; if (window !== w2) begin bad++; $display("FAIL c64_window got=%h exp=%h", window, w2); end
        // simultaneous load and consume
        shift_len = 7'd10; word = w3; valid = 1'b1;
        step();
        idle_inputs();
        exp_w = {w2[57:0], w3[67:58]};
        total++; if (count !== 8'd126) begin bad++; $display("FAIL lc_count got=%0d exp=126", count); end
        total++; if (window !== exp_w) begin bad++; $display("FAIL lc_window got=%h exp=%h", window, exp_w); end
    endtask

    task automatic test_zero_shift();
        do_reset();
        word = w1; valid = 1'b1;
        step();
        word = w2; consume = 1'b1; shift_len = 7'd0;
        step();
        idle_inputs();
        total++; if (count !== 8'd136 || window !== w1) begin bad++; $display("FAIL zero_shift got=%0d/%h exp=136/%h", count, window, w1); end
    endtask

    task automatic test_drain();
        do_reset();
        word = w4; valid = 1'b1; last = 1'b1;
        step();
        idle_inputs();
        total++; if (count !== 8'd68 || ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL drain_load got=%0d/%b/%b exp=68/0/0", count, ready, done); end
        consume = 1'b1; shift_len = 7'd30;
        step();
        exp_w = {w4[37:0], 30'd0};
        total++; if (count !== 8'd38 || ovalid !== 1'b1) begin bad++; $display("FAIL drain30 got=%0d/%b exp=38/1", count, ovalid); end
        total++; if (window !== exp_w) begin bad++; $display("FAIL drain30_window got=%h exp=%h", window, exp_w); end
        shift_len = 7'd38;
        step();
        idle_inputs();
        total++; if (count !== 8'd0 || done !== 1'b1 || ovalid !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL drain_done got=%0d/%b/%b/%b exp=0/1/0/0", count, done, ovalid, ready); end
        step();
        total++; if (done !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL after_done got=%b/%b exp=0/1", done, ready); end
    endtask

    task automatic test_over_consume();
        do_reset();
        word = w3; valid = 1'b1; last = 1'b1;
        step();
        idle_inputs();
        consume = 1'b1; shift_len = 7'd48;
        step();
        total++; if (count !== 8'd20 || err !== 1'b0) begin bad++; $display("FAIL pre_over got=%0d/%b exp=20/0", count, err); end
        shift_len = 7'd25;
        step();
        idle_inputs();
        total++; if (count !== 8'd0 || err !== 1'b1) begin bad++; $display("FAIL over got=%0d/%b exp=0/1", count, err); end
        step(); step(); step();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
        do_reset();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        word = w2; valid = 1'b1;
        step();
        word = w3; consume = 1'b1; shift_len = 7'd36;
        step();
        total++; if (count !== 8'd100) begin bad++; $display("FAIL mid_pre got=%0d exp=100", count); end
        reset = 1'b1; valid = 1'b1; consume = 1'b1; shift_len = 7'd10;
        step();
        reset = 1'b0;
        idle_inputs();
        total++; if (count !== 8'd0 || ovalid !== 1'b0 || window !== 68'd0 || err !== 1'b0) begin bad++; $display("FAIL mid_reset got=%0d/%b/%h/%b exp=0/0/0/0", count, ovalid, window, err); end
    endtask

    initial begin
        test_reset();
        test_double_load();
        test_zero_shift();
        test_drain();
        test_over_consume();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
